hybrid_buffer_fill_driver: RTL and testbench
============================================

Name: hybrid_buffer_fill_driver

Overview:
Write-side controller for the hybrid slot buffer; the counterpart of the pop driver on the read side. Accepts a valid/ready word stream and distributes it word-interleaved across BUFFER_SLOTS slot FIFOs: word k goes to slot k mod BUFFER_SLOTS, at depth index k / BUFFER_SLOTS. This ordering ensures each read-side pulse finds one new word in every slot. Once fill_limit words per slot are written, it reports full and issues a one-cycle dump start to the read side.

Parameters:
BUFFER_SLOTS, 16, number of slot FIFOs; power of two not required.
MAX_PULSES_PER_SLOT, 1024, depth bound; CW = $clog2(MAX_PULSES_PER_SLOT).
DATA_WIDTH, 32, width of one slot word.

Ports:
core_clk  in  1  clock.
resetn  in  1  reset; asynchronous, active-low.
begin_fill  in  1  pulse; starts a new fill and samples fill_limit.
fill_limit  in  CW  words per slot; 0 is treated as 1.
in_valid  in  1  upstream word valid.
in_ready  out  1  upstream ready.
in_data  in  DATA_WIDTH  upstream word.
slot_full  in  BUFFER_SLOTS  per-slot FIFO full (backpressure).
slot_push  out  BUFFER_SLOTS  one-hot write strobe, registered.
slot_wr_data  out  DATA_WIDTH  write data, registered.
slot_wr_addr  out  CW  depth index of the write, registered.
fill_done  out  1  level; high while in FULL.
dump_req  in  1  read side requests a dump.
begin_dump  out  1  one-cycle pulse to the read-side pop driver.
fill_error  out  1  sticky error flag (optional feature).

Behaviour:
- Reset values: state=IDLE; in_ready, slot_push, slot_wr_data, slot_wr_addr, fill_done, begin_dump and fill_error all 0; slot index and depth counters 0.
- States: IDLE, FILL, FULL.
- IDLE: in_ready=0.
  - begin_fill -> FILL; latch limit = max(fill_limit,1); clear slot_idx and depth.
- FILL: in_ready = !slot_full[slot_idx] (combinational from the registered index).
  - Handshake = in_valid && in_ready.
  - On handshake, next cycle: slot_push = onehot(slot_idx), slot_wr_data = in_data, slot_wr_addr = depth. Latency 1.
  - Otherwise slot_push=0 next cycle. slot_wr_data and slot_wr_addr hold their last values.
  - Index update on handshake: slot_idx increments. At BUFFER_SLOTS-1 it wraps to 0 and depth increments.
  - Handshake at slot_idx==BUFFER_SLOTS-1 and depth==limit-1 -> FULL. in_ready is 0 from the following cycle.
- FULL: fill_done=1, in_ready=0.
  - dump_req -> begin_dump=1 for exactly one cycle, then IDLE.
  - begin_dump is registered: it asserts in the cycle after dump_req is sampled, and fill_done falls in that same cycle.
- begin_fill during FILL or FULL: abort and restart. Counters clear, limit re-latches, state=FILL. Words already pushed stay in the FIFOs; flushing them is the owner's responsibility.
- begin_fill and dump_req in the same FULL cycle: begin_fill wins and no begin_dump is issued.
- dump_req outside FULL is ignored.
- Asynchronous reset mid-fill: everything returns to reset values immediately.
- Counter arithmetic: depth is CW bits and never exceeds limit-1, so no overflow. slot_idx is $clog2(BUFFER_SLOTS) bits with an explicit wrap, not a natural overflow.

Optional Feature:
HYBRID_BUFFER_FILL_ERROR_CHECK_EN.
- Defined: fill_error becomes sticky high on either event:
  - in_valid=1 while state != FILL, or
  - any slot_push to a slot whose slot_full is high in the same cycle.
- fill_error clears only on reset or begin_fill.
- Undefined: fill_error is tied to 0 and no checking logic is generated.

Decomposition:
- Package hybrid_buffer_pkg holds:
  - the fill_state_t enum (IDLE, FILL, FULL);
  - the CW width function/localparam helper;
  - a shared slot-count typedef, also used by the pop driver.
- One sub-module: slot_onehot_rotator. It holds the index counter with wrap, produces the one-hot decode, and emits a wrap pulse that advances depth.

Test Plan:
- Basic fill, BUFFER_SLOTS=4, fill_limit=3, continuous in_valid, data 0..11:
  - slot_push sequence is 0001,0010,0100,1000 repeated 3 times;
  - addresses 0,0,0,0,1,1,1,1,2,2,2,2;
  - fill_done rises the cycle after the 12th handshake.
- Backpressure: slot_full[2]=1 for 5 cycles while slot_idx=2:
  - in_ready=0 throughout and no push;
  - the word resumes to slot 2 unchanged after release.
- fill_limit=0 -> exactly BUFFER_SLOTS words accepted, all at addr 0, then FULL.
- Dump handshake: in FULL, dump_req pulses -> begin_dump high for one cycle the next cycle, then IDLE.
  - A held dump_req yields only one begin_dump.
- Abort: begin_fill after 7 words -> counters restart, next push targets slot 0 addr 0.
  - Simultaneous begin_fill and dump_req in FULL -> no begin_dump, state=FILL.
- Reset asserted mid-fill -> all outputs 0 asynchronously.
  - With HYBRID_BUFFER_FILL_ERROR_CHECK_EN, in_valid in IDLE sets fill_error, which is cleared by begin_fill.

Source files
------------

// File: rtl/hybrid_buffer_fill_driver_pkg.sv
// Shared types for the hybrid slot buffer fill/pop drivers.
package hybrid_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } fill_state_t;

  typedef logic [15:0] slot_count_t;

  localparam slot_count_t DEFAULT_BUFFER_SLOTS = 16'd16;

  function automatic int cw_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/hybrid_buffer_fill_driver_if.sv
// Upstream word stream plus slot FIFO write port of the hybrid buffer fill side.
interface hybrid_buffer_fill_driver_if #(
  parameter int BUFFER_SLOTS = 16,
  parameter int CW           = 10,
  parameter int DATA_WIDTH   = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_data;
  logic [BUFFER_SLOTS-1:0] slot_full;
  logic [BUFFER_SLOTS-1:0] slot_push;
  logic [DATA_WIDTH-1:0]   slot_wr_data;
  logic [CW-1:0]           slot_wr_addr;

  modport master (
    output in_valid, in_data, slot_full,
    input  in_ready, slot_push, slot_wr_data, slot_wr_addr
  );

  modport slave (
    input  in_valid, in_data, slot_full,
    output in_ready, slot_push, slot_wr_data, slot_wr_addr
  );
endinterface

// File: rtl/hybrid_buffer_fill_driver_rotator.sv
// Slot index counter with explicit wrap, one-hot decode and wrap pulse.
module slot_onehot_rotator #(
  parameter int BUFFER_SLOTS = 16,
  parameter int IW           = (BUFFER_SLOTS > 1) ? $clog2(BUFFER_SLOTS) : 1
) (
  input  logic                    core_clk,
  input  logic                    resetn,
  input  logic                    i_clr,
  input  logic                    i_adv,
  output logic [IW-1:0]           o_idx,
  output logic [BUFFER_SLOTS-1:0] o_onehot,
  output logic                    o_wrap
);
  logic [IW-1:0] r_idx;
  logic          w_last;

  assign w_last   = (r_idx == IW'(BUFFER_SLOTS - 1));
  assign o_wrap   = i_adv && w_last;
  assign o_idx    = r_idx;
  assign o_onehot = BUFFER_SLOTS'(1) << r_idx;

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_adv) begin
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end
endmodule

// File: rtl/hybrid_buffer_fill_driver.sv
// Write-side controller of the hybrid slot buffer: interleaves a word stream across slot FIFOs.
// Optional sticky protocol error flag: HYBRID_BUFFER_FILL_ERROR_CHECK_EN.
module hybrid_buffer_fill_driver
  import hybrid_buffer_pkg::*;
#(
  parameter int BUFFER_SLOTS        = 16,
  parameter int MAX_PULSES_PER_SLOT = 1024,
  parameter int DATA_WIDTH          = 32,
  parameter int CW                  = cw_width(MAX_PULSES_PER_SLOT)
) (
  input  logic                          core_clk,
  input  logic                          resetn,
  input  logic                          i_begin_fill,
  input  logic [CW-1:0]                 i_fill_limit,
  input  logic                          i_dump_req,
  hybrid_buffer_fill_driver_if.slave    bus,
  output logic                          o_fill_done,
  output logic                          o_begin_dump,
  output logic                          o_fill_error
);
  // state | meaning
  // IDLE  | waiting for begin_fill, upstream stalled
  // FILL  | accepting words, slot k mod N at depth k / N
  // FULL  | limit reached, waiting for the read side to request a dump
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_FILL = ST_FILL;
  localparam logic [1:0] S_FULL = ST_FULL;
  localparam int IW = (BUFFER_SLOTS > 1) ? $clog2(BUFFER_SLOTS) : 1;

  logic [1:0]              r_state;
  logic [CW-1:0]           r_limit;
  logic [CW-1:0]           r_depth;
  logic [BUFFER_SLOTS-1:0] r_slot_push;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic [CW-1:0]           r_wr_addr;
  logic                    r_begin_dump;

  logic [IW-1:0]           w_idx;
  logic [BUFFER_SLOTS-1:0] w_onehot;
  logic                    w_wrap;
  logic                    w_ready;
  logic                    w_hs;

  assign w_ready = (r_state == S_FILL) && !bus.slot_full[w_idx];
  assign w_hs    = bus.in_valid && w_ready;

  slot_onehot_rotator #(
    .BUFFER_SLOTS (BUFFER_SLOTS),
    .IW           (IW)
  ) u_rotator (
    .core_clk (core_clk),
    .resetn   (resetn),
    .i_clr    (i_begin_fill),
    .i_adv    (w_hs && !i_begin_fill),
    .o_idx    (w_idx),
    .o_onehot (w_onehot),
    .o_wrap   (w_wrap)
  );

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_limit      <= CW'(1);
      r_depth      <= '0;
      r_slot_push  <= '0;
      r_wr_data    <= '0;
      r_wr_addr    <= '0;
      r_begin_dump <= 1'b0;
    end else begin
      r_slot_push  <= '0;
      r_begin_dump <= 1'b0;
      // A restart overrides any handshake or dump request in the same cycle.
      if (i_begin_fill) begin
        r_state <= S_FILL;
        r_limit <= (i_fill_limit == '0) ? CW'(1) : i_fill_limit;
        r_depth <= '0;
      end else begin
        case (r_state)
          S_FILL: begin
            if (w_hs) begin
              r_slot_push <= w_onehot;
              r_wr_data   <= bus.in_data;
              r_wr_addr   <= r_depth;
              if (w_wrap) begin
                if (r_depth == r_limit - 1'b1) begin
                  r_state <= S_FULL;
                  r_depth <= '0;
                end else begin
                  r_depth <= r_depth + 1'b1;
                end
              end
            end
          end
          S_FULL: begin
            if (i_dump_req) begin
              r_begin_dump <= 1'b1;
              r_state      <= S_IDLE;
            end
          end
          S_IDLE: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready     = w_ready;
  assign bus.slot_push    = r_slot_push;
  assign bus.slot_wr_data = r_wr_data;
  assign bus.slot_wr_addr = r_wr_addr;
  assign o_fill_done      = (r_state == S_FULL);
  assign o_begin_dump     = r_begin_dump;

`ifdef HYBRID_BUFFER_FILL_ERROR_CHECK_EN
  logic r_fill_error;

  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      r_fill_error <= 1'b0;
    end else if (i_begin_fill) begin
      r_fill_error <= 1'b0;
    end else if ((bus.in_valid && (r_state != S_FILL)) ||
                 (|(r_slot_push & bus.slot_full))) begin
      r_fill_error <= 1'b1;
    end
  end

  assign o_fill_error = r_fill_error;
`else
  assign o_fill_error = 1'b0;
`endif
endmodule

// File: tb/tb_hybrid_buffer_fill_driver.sv
// Self-checking bench: word-count reference model plus directed and random stimulus.
module tb_hybrid_buffer_fill_driver;
  localparam int S    = 4;
  localparam int MAXP = 8;
  localparam int CW   = 3;
  localparam int DW   = 32;

  localparam logic [S-1:0] T1_PUSH [12] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                            4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                            4'b0001, 4'b0010, 4'b0100, 4'b1000};
  localparam int T1_ADDR [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
  localparam logic [S-1:0] T2_PUSH [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  logic          core_clk = 1'b0;
  logic          resetn   = 1'b0;
  logic          bf       = 1'b0;
  logic [CW-1:0] fl       = '0;
  logic          dr       = 1'b0;
  logic          o_fill_done, o_begin_dump, o_fill_error;

  hybrid_buffer_fill_driver_if #(.BUFFER_SLOTS(S), .CW(CW), .DATA_WIDTH(DW)) intf ();

  hybrid_buffer_fill_driver #(
    .BUFFER_SLOTS(S), .MAX_PULSES_PER_SLOT(MAXP), .DATA_WIDTH(DW), .CW(CW)
  ) dut (
    .core_clk     (core_clk),
    .resetn       (resetn),
    .i_begin_fill (bf),
    .i_fill_limit (fl),
    .i_dump_req   (dr),
    .bus          (intf.slave),
    .o_fill_done  (o_fill_done),
    .o_begin_dump (o_begin_dump),
    .o_fill_error (o_fill_error)
  );

  always #5 core_clk = ~core_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0=idle 1=fill 2=full, m_k = words accepted in this fill.
  int            m_mode = 0;
  int            m_k    = 0;
  int            m_limit = 1;
  logic [S-1:0]  e_push = '0;
  logic [DW-1:0] e_data = '0;
  int            e_addr = 0;
  logic          e_bd   = 1'b0;
  logic          e_err  = 1'b0;

  logic [S-1:0]  lg_push [$];
  int            lg_addr [$];
  logic [DW-1:0] lg_data [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_log();
    lg_push.delete();
    lg_addr.delete();
    lg_data.delete();
  endtask

  // Entered and left just after a falling edge; inputs are already driven.
  task automatic cycle();
    logic exp_rdy, hs;
    int   slot;
    #1;
    slot    = m_k % S;
    exp_rdy = (m_mode == 1) && !intf.slot_full[slot];
    chk("in_ready", {63'd0, intf.in_ready}, {63'd0, exp_rdy});
    hs = exp_rdy && intf.in_valid;
`ifdef HYBRID_BUFFER_FILL_ERROR_CHECK_EN
    if ((intf.in_valid && m_mode != 1) || ((e_push & intf.slot_full) != '0)) e_err = 1'b1;
`endif
    e_push = '0;
    e_bd   = 1'b0;
    if (bf) begin
      m_mode  = 1;
      m_k     = 0;
      m_limit = (fl == '0) ? 1 : int'(fl);
      e_err   = 1'b0;
    end else if (m_mode == 1 && hs) begin
      e_push = S'(1) << slot;
      e_data = intf.in_data;
      e_addr = m_k / S;
      m_k++;
      if (m_k == S * m_limit) m_mode = 2;
    end else if (m_mode == 2 && dr) begin
      e_bd   = 1'b1;
      m_mode = 0;
    end
    @(posedge core_clk);
    #1;
    chk("slot_push", {60'd0, intf.slot_push}, {60'd0, e_push});
    chk("slot_wr_data", {32'd0, intf.slot_wr_data}, {32'd0, e_data});
    chk("slot_wr_addr", {61'd0, intf.slot_wr_addr}, 64'(e_addr));
    chk("fill_done", {63'd0, o_fill_done}, {63'd0, (m_mode == 2)});
    chk("begin_dump", {63'd0, o_begin_dump}, {63'd0, e_bd});
    chk("fill_error", {63'd0, o_fill_error}, {63'd0, e_err});
    if (intf.slot_push != '0) begin
      lg_push.push_back(intf.slot_push);
      lg_addr.push_back(int'(intf.slot_wr_addr));
      lg_data.push_back(intf.slot_wr_data);
    end
    @(negedge core_clk);
  endtask

  task automatic do_reset();
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_push", {60'd0, intf.slot_push}, 64'd0);
    chk("rst_data", {32'd0, intf.slot_wr_data}, 64'd0);
    chk("rst_addr", {61'd0, intf.slot_wr_addr}, 64'd0);
    chk("rst_ready", {63'd0, intf.in_ready}, 64'd0);
    chk("rst_done", {63'd0, o_fill_done}, 64'd0);
    chk("rst_dump", {63'd0, o_begin_dump}, 64'd0);
    chk("rst_err", {63'd0, o_fill_error}, 64'd0);
    m_mode = 0; m_k = 0; m_limit = 1;
    e_push = '0; e_data = '0; e_addr = 0; e_bd = 1'b0; e_err = 1'b0;
    @(negedge core_clk);
    resetn = 1'b1;
  endtask

  initial begin
    intf.in_valid  = 1'b0;
    intf.in_data   = '0;
    intf.slot_full = '0;
    @(negedge core_clk);
    chk("init_push", {60'd0, intf.slot_push}, 64'd0);
    chk("init_done", {63'd0, o_fill_done}, 64'd0);
    chk("init_ready", {63'd0, intf.in_ready}, 64'd0);
    resetn = 1'b1;

    // Basic fill: limit 3, words 0..11, then a held dump request.
    clear_log();
    bf = 1'b1; fl = 3'd3; cycle(); bf = 1'b0;
    for (int j = 0; j < 12; j++) begin
      intf.in_valid = 1'b1; intf.in_data = DW'(j);
      cycle();
      chk("t1_done", {63'd0, o_fill_done}, {63'd0, (j == 11)});
    end
    intf.in_valid = 1'b0;
    chk("t1_count", 64'(lg_push.size()), 64'd12);
    for (int j = 0; j < 12 && j < lg_push.size(); j++) begin
      chk("t1_push", {60'd0, lg_push[j]}, {60'd0, T1_PUSH[j]});
      chk("t1_addr", 64'(lg_addr[j]), 64'(T1_ADDR[j]));
      chk("t1_data", {32'd0, lg_data[j]}, 64'(j));
    end
    dr = 1'b1;
    cycle(); chk("t1_bd0", {63'd0, o_begin_dump}, 64'd1); chk("t1_done_fall", {63'd0, o_fill_done}, 64'd0);
    cycle(); chk("t1_bd1", {63'd0, o_begin_dump}, 64'd0);
    cycle(); chk("t1_bd2", {63'd0, o_begin_dump}, 64'd0);
    dr = 1'b0;

    // Limit 0 acts as 1; backpressure on slot 2 for five cycles.
    clear_log();
    bf = 1'b1; fl = 3'd0; cycle(); bf = 1'b0;
    intf.in_valid = 1'b1;
    intf.in_data = 32'd100; cycle();
    intf.in_data = 32'd101; cycle();
    intf.in_data = 32'd102; intf.slot_full = 4'b0100;
    repeat (5) begin
      cycle();
      chk("t2_bp_ready", {63'd0, intf.in_ready}, 64'd0);
      chk("t2_bp_count", 64'(lg_push.size()), 64'd2);
    end
    intf.slot_full = '0; cycle();
    intf.in_data = 32'd103; cycle();
    intf.in_valid = 1'b0;
    chk("t2_count", 64'(lg_push.size()), 64'd4);
    for (int j = 0; j < 4 && j < lg_push.size(); j++) begin
      chk("t2_push", {60'd0, lg_push[j]}, {60'd0, T2_PUSH[j]});
      chk("t2_addr", 64'(lg_addr[j]), 64'd0);
      chk("t2_data", {32'd0, lg_data[j]}, 64'(100 + j));
    end
    chk("t2_done", {63'd0, o_fill_done}, 64'd1);

    // Abort after 7 words, refill to FULL, then begin_fill beats dump_req.
    bf = 1'b1; fl = 3'd2; cycle(); bf = 1'b0;
    intf.in_valid = 1'b1;
    for (int j = 0; j < 7; j++) begin intf.in_data = DW'(200 + j); cycle(); end
    clear_log();
    bf = 1'b1; intf.in_data = 32'd999; cycle(); bf = 1'b0;
    chk("t3_abort_nopush", {60'd0, intf.slot_push}, 64'd0);
    intf.in_data = 32'h55; cycle();
    chk("t3_restart_push", {60'd0, intf.slot_push}, 64'd1);
    chk("t3_restart_addr", {61'd0, intf.slot_wr_addr}, 64'd0);
    chk("t3_restart_data", {32'd0, intf.slot_wr_data}, 64'h55);
    for (int j = 0; j < 7; j++) begin intf.in_data = DW'(j); cycle(); end
    intf.in_valid = 1'b0;
    chk("t3_full", {63'd0, o_fill_done}, 64'd1);
    bf = 1'b1; dr = 1'b1; fl = 3'd1; cycle(); bf = 1'b0; dr = 1'b0;
    chk("t3_race_bd", {63'd0, o_begin_dump}, 64'd0);
    chk("t3_race_done", {63'd0, o_fill_done}, 64'd0);
    #1; chk("t3_race_fill", {63'd0, intf.in_ready}, 64'd1);
    @(negedge core_clk);

    // Asynchronous reset in the middle of a fill.
    intf.in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin intf.in_data = DW'(300 + j); cycle(); end
    intf.in_valid = 1'b0;
    do_reset();

`ifdef HYBRID_BUFFER_FILL_ERROR_CHECK_EN
    intf.in_valid = 1'b1; cycle(); intf.in_valid = 1'b0;
    chk("err_set", {63'd0, o_fill_error}, 64'd1);
    bf = 1'b1; fl = 3'd1; cycle(); bf = 1'b0;
    chk("err_clear", {63'd0, o_fill_error}, 64'd0);
`endif

    // Random traffic against the model.
    repeat (4000) begin
      bf             = ($urandom_range(0, 119) == 0);
      fl             = CW'($urandom_range(0, 7));
      intf.in_valid  = ($urandom_range(0, 9) < 7);
      intf.in_data   = $urandom;
      intf.slot_full = ($urandom_range(0, 3) == 0) ? S'($urandom) : '0;
      dr             = ($urandom_range(0, 4) == 0);
      if (m_mode == 0 && $urandom_range(0, 7) == 0) bf = 1'b1;
      cycle();
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
